// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch memory with combinational read, boot image on reset, loader write port
module fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ins,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Boot program: words 0-7 are fixed, everything above is a NOP.
    function automatic logic [DATA_WIDTH-1:0] boot_word(input int unsigned a);
        logic [DATA_WIDTH-1:0] w;
        case (a)
            0:       w = DATA_WIDTH'(32'h20010005);
            1:       w = DATA_WIDTH'(32'h2002000A);
            2:       w = DATA_WIDTH'(32'h00221820);
            3:       w = DATA_WIDTH'(32'hAC030010);
            4:       w = DATA_WIDTH'(32'h8C040010);
            5:       w = DATA_WIDTH'(32'h1083FFFF);
            6:       w = DATA_WIDTH'(32'h08000000);
            7:       w = DATA_WIDTH'(32'hFFFFFFFF);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Reset reloads every word and dominates a simultaneous loader write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= boot_word(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ins = mem[pc];

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for fetch
`timescale 1ns/1ps
module tb_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic [31:0] ins;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    int tests_run;
    int tests_failed;

    logic [31:0] boot_exp [9];

    fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .pc    (pc),
        .ins   (ins),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic test_reset();
        #10 rst = 1'b0;
        #1;
        tests_run++;
        if (ins !== 32'h20010005) begin
            tests_failed++;
            $display("FAIL reset_word0: ins=%h expected %h", ins, 32'h20010005);
        end
        pc = 8'd7;
        #1;
        tests_run++;
        if (ins !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL reset_word7: ins=%h expected %h", ins, 32'hFFFFFFFF);
        end
        pc = 8'd0;
        #18 rst = 1'b1;
    endtask

    task automatic test_fetch_sequence();
        boot_exp = '{32'h20010005, 32'h2002000A, 32'h00221820, 32'hAC030010,
                     32'h8C040010, 32'h1083FFFF, 32'h08000000, 32'hFFFFFFFF,
                     32'h00000000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tests_run++;
            if (ins !== boot_exp[i]) begin
                tests_failed++;
                $display("FAIL fetch_pc%0d: ins=%h expected %h", i, ins, boot_exp[i]);
            end
            @(posedge clk);
            #1 pc = pc + 8'd1;
        end
    endtask

    task automatic test_comb_read();
        @(negedge clk);
        pc = 8'd7;
        #1;
        tests_run++;
        if (ins !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL comb_pc7: ins=%h expected %h", ins, 32'hFFFFFFFF);
        end
        #5 pc = 8'd8;
        #1;
        tests_run++;
        if (ins !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL comb_pc8: ins=%h expected %h", ins, 32'h00000000);
        end
    endtask

    task automatic test_loader_write();
        @(negedge clk);
        pc = 8'd20; we = 1'b1; waddr = 8'd20; wdata = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (ins !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL write_before_edge: ins=%h expected %h", ins, 32'h00000000);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (ins !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_after_edge: ins=%h expected %h", ins, 32'hDEADBEEF);
        end
        we = 1'b0;
        pc = 8'd21;
        #1;
        tests_run++;
        if (ins !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL write_neighbour: ins=%h expected %h", ins, 32'h00000000);
        end
    endtask

    task automatic test_overwrite_boot();
        @(negedge clk);
        pc = 8'd0; we = 1'b1; waddr = 8'd0; wdata = 32'h12345678;
        @(posedge clk);
        #1 we = 1'b0;
        tests_run++;
        if (ins !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL overwrite_word0: ins=%h expected %h", ins, 32'h12345678);
        end
        #10 rst = 1'b0;
        #1;
        tests_run++;
        if (ins !== 32'h20010005) begin
            tests_failed++;
            $display("FAIL async_reset_word0: ins=%h expected %h", ins, 32'h20010005);
        end
        pc = 8'd20;
        #1;
        tests_run++;
        if (ins !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL reset_discards_write: ins=%h expected %h", ins, 32'h00000000);
        end
        #5 rst = 1'b1;
    endtask

    task automatic test_write_during_reset();
        @(negedge clk);
        rst = 1'b0; we = 1'b1; waddr = 8'd5; wdata = 32'hAAAAAAAA; pc = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (ins !== 32'h1083FFFF) begin
            tests_failed++;
            $display("FAIL write_in_reset_held: ins=%h expected %h", ins, 32'h1083FFFF);
        end
        @(negedge clk);
        we = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (ins !== 32'h1083FFFF) begin
            tests_failed++;
            $display("FAIL write_in_reset_released: ins=%h expected %h", ins, 32'h1083FFFF);
        end
    endtask

    task automatic test_top_address();
        @(negedge clk);
        we = 1'b1; waddr = 8'd255; wdata = 32'hCAFEF00D; pc = 8'd255;
        #1;
        tests_run++;
        if (ins !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL top_no_bypass: ins=%h expected %h", ins, 32'h00000000);
        end
        @(posedge clk);
        #1 we = 1'b0;
        tests_run++;
        if (ins !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL top_word255: ins=%h expected %h", ins, 32'hCAFEF00D);
        end
        pc = 8'd0;
        #1;
        tests_run++;
        if (ins !== 32'h20010005) begin
            tests_failed++;
            $display("FAIL top_wrap_word0: ins=%h expected %h", ins, 32'h20010005);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pc = 8'd40;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1;
            waddr = 8'(41 + i);
            wdata = 32'h0BAD0000 + 32'(i);
            @(posedge clk);
            #1;
            tests_run++;
            if (ins !== 32'h00000000) begin
                tests_failed++;
                $display("FAIL b2b_undisturbed_%0d: ins=%h expected %h", i, ins, 32'h00000000);
            end
        end
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 8'(41 + i);
            #1;
            tests_run++;
            if (ins !== 32'h0BAD0000 + 32'(i)) begin
                tests_failed++;
                $display("FAIL b2b_read_%0d: ins=%h expected %h", i, ins, 32'h0BAD0000 + 32'(i));
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        pc    = 8'd0;
        we    = 1'b0;
        waddr = 8'd0;
        wdata = 32'd0;

        test_reset();
        test_fetch_sequence();
        test_comb_read();
        test_loader_write();
        test_overwrite_boot();
        test_write_during_reset();
        test_top_address();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
